// File: rtl/multi_channel_control_queue.sv
`default_nettype none
// ============================================================================
// Module      : multi_channel_control_queue
// Description : CHANNELS independent DEPTH-entry FIFOs with per-channel push,
//               pop, flush, occupancy and almost-full; head data is read
//               combinationally. Optional sticky overflow/underflow flags are
//               built when RSD_CTRL_QUEUE_ERROR_CHECK_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_channel_control_queue #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int CHANNELS   = 2,
    parameter int AF_MARGIN  = 2,
    localparam int CW        = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [CHANNELS-1:0]            push,
    input  logic [CHANNELS*DATA_WIDTH-1:0] pushData,
    input  logic [CHANNELS-1:0]            pop,
    input  logic [CHANNELS-1:0]            flush,
    output logic [CHANNELS-1:0]            full,
    output logic [CHANNELS-1:0]            empty,
    output logic [CHANNELS-1:0]            almostFull,
    output logic [CHANNELS*CW-1:0]         count,
    output logic [CHANNELS*DATA_WIDTH-1:0] headData,
    output logic [CHANNELS-1:0]            overflow,
    output logic [CHANNELS-1:0]            underflow
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [CW-1:0] c_FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] c_AF_CNT   = CW'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] c_CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] c_PTR_ONE  = AW'(1);

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        logic [DATA_WIDTH-1:0] r_mem [DEPTH];
        logic [AW-1:0]         r_head;
        logic [AW-1:0]         r_tail;
        logic [CW-1:0]         r_count;
        logic                  w_full;
        logic                  w_empty;
        logic                  w_push_ok;
        logic                  w_pop_ok;

        assign w_full    = (r_count == c_FULL_CNT);
        assign w_empty   = (r_count == '0);
        // A pop on a full queue frees the slot the simultaneous push lands in.
        assign w_push_ok = push[c] & (~w_full | pop[c]);
        assign w_pop_ok  = pop[c] & ~w_empty;

        always_ff @(posedge clk) begin
            if (!rst || flush[c]) begin
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_push_ok)
                    r_tail <= r_tail + c_PTR_ONE;
                if (w_pop_ok)
                    r_head <= r_head + c_PTR_ONE;
                if (w_push_ok && !w_pop_ok)
                    r_count <= r_count + c_CNT_ONE;
                else if (!w_push_ok && w_pop_ok)
                    r_count <= r_count - c_CNT_ONE;
            end
        end

        // Storage is never reset; only the pointers define what is valid.
        always_ff @(posedge clk) begin
            if (rst && !flush[c] && w_push_ok)
                r_mem[r_tail] <= pushData[c*DATA_WIDTH +: DATA_WIDTH];
        end

        assign full[c]                              = w_full;
        assign empty[c]                             = w_empty;
        assign almostFull[c]                        = (r_count >= c_AF_CNT);
        assign count[c*CW +: CW]                    = r_count;
        assign headData[c*DATA_WIDTH +: DATA_WIDTH] = r_mem[r_head];

`ifdef RSD_CTRL_QUEUE_ERROR_CHECK_EN
        logic r_ovf;
        logic r_udf;

        always_ff @(posedge clk) begin
            if (!rst || flush[c]) begin
                r_ovf <= 1'b0;
                r_udf <= 1'b0;
            end else begin
                if (push[c] && w_full && !pop[c])
                    r_ovf <= 1'b1;
                if (pop[c] && w_empty)
                    r_udf <= 1'b1;
            end
        end

        assign overflow[c]  = r_ovf;
        assign underflow[c] = r_udf;
`else
        assign overflow[c]  = 1'b0;
        assign underflow[c] = 1'b0;
`endif
    end

endmodule
`default_nettype wire

// File: tb/tb_multi_channel_control_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_channel_control_queue
// Description : Directed plus randomized bench for multi_channel_control_queue
//               against a shift-list FIFO reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_channel_control_queue;

    localparam int DW = 8;
    localparam int DP = 4;
    localparam int CH = 2;
    localparam int AF = 2;
    localparam int CW = $clog2(DP + 1);

    logic              clk = 1'b0;
    logic              rst;
    logic [CH-1:0]     push;
    logic [CH*DW-1:0]  pushData;
    logic [CH-1:0]     pop;
    logic [CH-1:0]     flush;
    logic [CH-1:0]     full;
    logic [CH-1:0]     empty;
    logic [CH-1:0]     almostFull;
    logic [CH*CW-1:0]  count;
    logic [CH*DW-1:0]  headData;
    logic [CH-1:0]     overflow;
    logic [CH-1:0]     underflow;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: entry 0 is always the head; pops shift the list down.
    logic [DW-1:0] m_dat [CH][DP];
    int            m_sz  [CH];
    logic          m_ovf [CH];
    logic          m_udf [CH];

    multi_channel_control_queue #(
        .DATA_WIDTH (DW),
        .DEPTH      (DP),
        .CHANNELS   (CH),
        .AF_MARGIN  (AF)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .pushData   (pushData),
        .pop        (pop),
        .flush      (flush),
        .full       (full),
        .empty      (empty),
        .almostFull (almostFull),
        .count      (count),
        .headData   (headData),
        .overflow   (overflow),
        .underflow  (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_update(input logic r, input logic [CH-1:0] pu,
                                input logic [CH*DW-1:0] pd,
                                input logic [CH-1:0] po, input logic [CH-1:0] fl);
        for (int c = 0; c < CH; c++) begin
            logic is_full, is_empty, pop_ok, push_ok;
            if (!r || fl[c]) begin
                m_sz[c]  = 0;
                m_ovf[c] = 1'b0;
                m_udf[c] = 1'b0;
            end else begin
                is_full  = (m_sz[c] == DP);
                is_empty = (m_sz[c] == 0);
                pop_ok   = po[c] && !is_empty;
                push_ok  = pu[c] && (!is_full || po[c]);
`ifdef RSD_CTRL_QUEUE_ERROR_CHECK_EN
                if (pu[c] && is_full && !po[c]) m_ovf[c] = 1'b1;
                if (po[c] && is_empty)          m_udf[c] = 1'b1;
`endif
                if (pop_ok) begin
                    for (int i = 0; i < DP - 1; i++) m_dat[c][i] = m_dat[c][i+1];
                    m_sz[c]--;
                end
                if (push_ok) begin
                    m_dat[c][m_sz[c]] = pd[c*DW +: DW];
                    m_sz[c]++;
                end
            end
        end
    endtask

    task automatic check_all();
        for (int c = 0; c < CH; c++) begin
            chk($sformatf("count[%0d]", c), 64'(count[c*CW +: CW]), 64'(m_sz[c]));
            chk($sformatf("empty[%0d]", c), 64'(empty[c]), 64'(m_sz[c] == 0));
            chk($sformatf("full[%0d]", c), 64'(full[c]), 64'(m_sz[c] == DP));
            chk($sformatf("almostFull[%0d]", c), 64'(almostFull[c]), 64'(m_sz[c] >= DP - AF));
            if (m_sz[c] > 0)
                chk($sformatf("headData[%0d]", c), 64'(headData[c*DW +: DW]), 64'(m_dat[c][0]));
            chk($sformatf("overflow[%0d]", c), 64'(overflow[c]), 64'(m_ovf[c]));
            chk($sformatf("underflow[%0d]", c), 64'(underflow[c]), 64'(m_udf[c]));
        end
    endtask

    // One clock: drive on the falling edge, model the rising edge, check 1 later.
    task automatic step(input logic r, input logic [CH-1:0] pu, input logic [CH*DW-1:0] pd,
                        input logic [CH-1:0] po, input logic [CH-1:0] fl);
        @(negedge clk);
        rst = r; push = pu; pushData = pd; pop = po; flush = fl;
        @(posedge clk);
        model_update(r, pu, pd, po, fl);
        #1;
        check_all();
    endtask

    initial begin
        logic ovf_exp;
        rst = 1'b0; push = '0; pushData = '0; pop = '0; flush = '0;
        for (int c = 0; c < CH; c++) begin
            m_sz[c] = 0; m_ovf[c] = 1'b0; m_udf[c] = 1'b0;
        end
`ifdef RSD_CTRL_QUEUE_ERROR_CHECK_EN
        ovf_exp = 1'b1;
`else
        ovf_exp = 1'b0;
`endif

        step(1'b0, 2'b00, 16'h0, 2'b00, 2'b00);
        chk("reset_empty", 64'(empty), 64'h3);
        chk("reset_count", 64'(count), 64'h0);

        // Fill ch0: A1..A4
        step(1'b1, 2'b01, 16'h00A1, 2'b00, 2'b00);
        step(1'b1, 2'b01, 16'h00A2, 2'b00, 2'b00);
        chk("af_at_2", 64'(almostFull[0]), 64'h1);
        step(1'b1, 2'b01, 16'h00A3, 2'b00, 2'b00);
        step(1'b1, 2'b01, 16'h00A4, 2'b00, 2'b00);
        chk("full_ch0", 64'(full[0]), 64'h1);
        chk("ch1_idle", 64'(count[CW +: CW]), 64'h0);

        // Dropped push while full
        step(1'b1, 2'b01, 16'h00FF, 2'b00, 2'b00);
        chk("drop_head", 64'(headData[0 +: DW]), 64'hA1);
        chk("drop_ovf", 64'(overflow[0]), 64'(ovf_exp));
        for (int i = 0; i < 4; i++) begin
            chk("drain_head", 64'(headData[0 +: DW]), 64'(8'hA1 + 8'(i)));
            step(1'b1, 2'b00, 16'h0, 2'b01, 2'b00);
        end
        chk("drained_empty", 64'(empty[0]), 64'h1);

        // Refill, then push+pop on full to exercise wrap-around
        for (int i = 0; i < 4; i++) step(1'b1, 2'b01, 16'(8'hA1 + 8'(i)), 2'b00, 2'b00);
        step(1'b1, 2'b01, 16'h00B5, 2'b01, 2'b00);
        chk("pp_full_head", 64'(headData[0 +: DW]), 64'hA2);
        for (int i = 0; i < 3; i++) step(1'b1, 2'b00, 16'h0, 2'b01, 2'b00);
        chk("wrap_head", 64'(headData[0 +: DW]), 64'hB5);

        // Push+pop on empty ch1
        step(1'b1, 2'b10, 16'hC100, 2'b10, 2'b00);
        chk("pp_empty_head", 64'(headData[DW +: DW]), 64'hC1);
        chk("pp_empty_udf", 64'(underflow[1]), 64'(ovf_exp));

        // ch0 to 3 entries, then flush with push and pop in the same cycle
        step(1'b1, 2'b01, 16'h0012, 2'b00, 2'b00);
        step(1'b1, 2'b01, 16'h0013, 2'b00, 2'b00);
        step(1'b1, 2'b01, 16'h0011, 2'b01, 2'b01);
        chk("flush_empty", 64'(empty[0]), 64'h1);
        chk("flush_ch1", 64'(headData[DW +: DW]), 64'hC1);

        // Mid-operation reset
        step(1'b1, 2'b11, 16'h3433, 2'b00, 2'b00);
        step(1'b0, 2'b11, 16'h3635, 2'b11, 2'b00);
        chk("rst_empty", 64'(empty), 64'h3);
        step(1'b1, 2'b01, 16'h0022, 2'b00, 2'b00);
        chk("post_rst_head", 64'(headData[0 +: DW]), 64'h22);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            logic          r;
            logic [CH-1:0] pu, po, fl;
            r  = ($urandom_range(0, 79) != 0);
            pu = CH'($urandom);
            po = CH'($urandom) & CH'($urandom);
            if (n % 200 > 100) po = CH'($urandom);
            fl = CH'($urandom_range(0, 15) == 0 ? $urandom : 0);
            step(r, pu, (CH*DW)'($urandom), po, fl);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_channel_control_queue.md
# multi_channel_control_queue

Parametrised, multi-channel successor of the PS–PL control queue. It provides CHANNELS independent FIFOs of DEPTH × DATA_WIDTH entries, each with its own push, pop, flush, occupancy count and almost-full flag. Head data is read combinationally. The block sits between the PS-side command/status path and PL consumers, one channel per command class, replacing single-channel fixed-size queues.

## Interface
- DATA_WIDTH, 64, bits per entry.
- DEPTH, 16, entries per channel; power of two, ≥ 2.
- CHANNELS, 2, number of independent queues; ≥ 1.
- AF_MARGIN, 2, almostFull asserts when free entries ≤ AF_MARGIN; 0 ≤ AF_MARGIN < DEPTH.
- clk  in  1  single clock, all state updates on rising edge.
- rst  in  1  reset, synchronous, active-low.
- push  in  CHANNELS  per-channel write request.
- pushData  in  CHANNELS×DATA_WIDTH  channel c at bits [c×DATA_WIDTH +: DATA_WIDTH].
- pop  in  CHANNELS  per-channel read-acknowledge; consumes the current head.
- flush  in  CHANNELS  per-channel discard of all contents.
- full  out  CHANNELS  count == DEPTH.
- empty  out  CHANNELS  count == 0.
- almostFull  out  CHANNELS  count ≥ DEPTH − AF_MARGIN.
- count  out  CHANNELS×CW  occupancy, CW = $clog2(DEPTH+1).
- headData  out  CHANNELS×DATA_WIDTH  entry at the head pointer; valid only when empty=0.
- overflow  out  CHANNELS  sticky: push dropped while full (see Configuration).
- underflow  out  CHANNELS  sticky: pop while empty (see Configuration).

## Operation
- Per channel: head pointer, tail pointer (each $clog2(DEPTH) bits, natural wrap from DEPTH−1 to 0), count register, storage array. There is no sharing between channels, and no channel's activity affects another.
- Accepted push: when push=1 and (full=0 or pop=1 in the same cycle, with full=1), write pushData to mem[tail] and increment tail.
- Accepted pop: when pop=1 and empty=0, increment head.
- count: +1 on an accepted push only, −1 on an accepted pop only, unchanged when both are accepted or neither is.
- Push while full without pop: dropped; the array, pointers and count are unchanged.
- Pop while empty: ignored. A simultaneous push is still accepted, giving count 1.
- Push and pop both accepted on a full queue: count stays DEPTH, and the write lands in the slot just vacated (tail == head before the update).
- Flush has priority over push and pop in the same cycle. It sets head = tail = 0 and count = 0. Array contents are not cleared.
- headData = mem[head] (combinational, distributed RAM). It is undefined while empty.
- full, empty and almostFull are decoded combinationally from the count register.

## Timing
- Reset (rst=0 at a clock edge) sets all pointers to 0, count to 0, empty to all-ones, and full, almostFull, overflow and underflow to 0. headData is undefined after reset. Array contents are not reset.
- Reset asserted mid-operation discards all channels' contents at that edge, and reset has priority over flush, push and pop. While rst=0, inputs are ignored.
- Write-to-read latency is 1 cycle: data pushed at edge N appears on headData after edge N, provided it is the head.
- Status outputs reflect the post-edge state in the same cycle. No status output has a combinational path from push or pop.
- Pop is an acknowledge with no handshake wait: the consumer samples headData while empty=0 and asserts pop in the same cycle.

## Configuration
- Macro RSD_CTRL_QUEUE_ERROR_CHECK_EN.
- Defined: overflow[c] sets on a dropped push and underflow[c] sets on a pop while empty. Both flags stay set until reset or flush[c].
- Undefined: overflow and underflow are tied to 0 and no flag registers are synthesised. Queue behaviour is otherwise identical.

## Test plan
- DEPTH=4, CHANNELS=2, ch0: push 0xA1, 0xA2, 0xA3, 0xA4 -> count=4, full=1, almostFull=1 from count 2 (AF_MARGIN=2). Ch1 stays empty=1, count=0.
- Full ch0: push 0xFF without pop -> dropped, count=4, headData=0xA1, overflow[0]=1 (macro on) or 0 (macro off). Then pop ×4 -> headData sequence 0xA1..0xA4, then empty=1.
- Full ch0: push 0xB5 and pop in the same cycle -> count stays 4, headData=0xA2. After three more pops, headData=0xB5, confirming wrap-around.
- Empty ch1: push 0xC1 and pop in the same cycle -> push accepted, count=1, headData=0xC1, underflow[1]=1 (macro on).
- Ch0 holding 3 entries: flush[0], push[0]=0x11 and pop[0] all in one cycle -> count=0, empty=1, overflow and underflow cleared. Ch1 contents unaffected.
- Both channels partially filled: rst=0 for one cycle during concurrent push and pop -> all counts 0, empty=all-ones, flags 0. Push 0x22 on the next cycle -> headData=0x22.
